// File: rtl/uart_dbg_rx_pkg.sv
// Shared definitions for the UART debug receive path: FSM state encoding and
// the baud-rate derivation that the transmit side uses too.
package uart_dbg_rx_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // System clocks per serial bit (integer division).
  function automatic int calc_clks_per_bit(input int sys_clk_freq, input int baud_rate);
    return sys_clk_freq / baud_rate;
  endfunction

  // Clocks from the start edge to the centre of the start bit.
  function automatic int calc_half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

  // Width of the bit-timing counter; at least one bit so it always exists.
  function automatic int calc_cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/fifo.sv
// Generic show-ahead FIFO. Depth must be a power of two (>= 2) so the
// pointers wrap naturally. The head reads as zero while the queue is empty.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic                  wr_en;
  logic                  rd_en;

  assign full  = (count_q == COUNT_FULL);
  assign empty = (count_q == '0);
  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Advance pointers and occupancy; a simultaneous push and pop cancel out.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchroniser, edge-triggered start detection,
// mid-bit sampling FSM and LSB-first shift register.
module uart_rx
  import uart_dbg_rx_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 48_000_000,
  parameter int BAUD_RATE    = 9_600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
  localparam int HALF         = calc_half_bit(CLKS_PER_BIT);
  localparam int CNT_W        = calc_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);

  // sync_q[0] is the metastability flop, sync_q[1] the synchronised line,
  // sync_q[2] its one-cycle-old copy used for falling-edge detection.
  logic [2:0]       sync_q, sync_d;
  logic             rx_s;
  logic             rx_prev;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;

  assign rx_s      = sync_q[1];
  assign rx_prev   = sync_q[2];
  assign data_out  = shift_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != RX_IDLE);

  // Shift the raw pin through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[1:0], rx};
  end

  // Receive FSM: start-edge qualify, bit sampling, stop check and break hold.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF_END) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d = '0;
          if (rx_s) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_BREAK: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // State registers; synchroniser resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= 3'b111;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: rtl/uart_dbg_rx.sv
// Receive-side debug port: UART receiver feeding a byte queue read by the
// fabric. A byte arriving while the queue is full is dropped and flagged.
module uart_dbg_rx
  import uart_dbg_rx_pkg::*;
#(
  parameter int SYS_CLK_FREQ   = 48_000_000,
  parameter int BAUD_RATE      = 9_600,
  parameter int MSG_QUEUE_SIZE = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] msg,
  output logic       full,
  output logic       empty,
  output logic       frame_err,
  output logic       overrun
);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy_unused;
  logic       fifo_wr;

  // Fullness is judged in the write cycle itself, so a same-cycle pop never
  // rescues the incoming byte.
  assign fifo_wr = rx_valid & ~full;
  assign overrun = rx_valid &  full;

  uart_rx #(
    .SYS_CLK_FREQ (SYS_CLK_FREQ),
    .BAUD_RATE    (BAUD_RATE)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_out  (rx_data),
    .valid     (rx_valid),
    .frame_err (frame_err),
    .busy      (rx_busy_unused)
  );

  fifo #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (MSG_QUEUE_SIZE)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (fifo_wr),
    .wr_data (rx_data),
    .rd      (rd),
    .rd_data (msg),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: doc/uart_dbg_rx.md
# uart_dbg_rx

Receive-side debug port: deserialises 8N1 UART frames from the `rx` pin and queues each received byte in a FIFO for the fabric to read. It is the host-to-design counterpart of the transmit debug queue. It shares the same clock, baud parameters and queue sizing, so both directions of one debug link are configured identically. Framing and overrun errors are reported as single-cycle pulses.

## Interface
- `SYS_CLK_FREQ`, 48_000_000: system clock in Hz.
- `BAUD_RATE`, 9_600: line rate in bit/s.
- `MSG_QUEUE_SIZE`, 32: FIFO depth in bytes; must be a power of two.

Ports:
- `clk` in 1: system clock, one clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `rx` in 1: serial input, asynchronous to `clk`, idles high.
- `rd` in 1: pop request; ignored while `empty`=1.
- `msg` out 8: head of queue, valid whenever `empty`=0 (show-ahead).
- `full` out 1: queue holds `MSG_QUEUE_SIZE` bytes.
- `empty` out 1: queue holds no bytes.
- `frame_err` out 1: one-cycle pulse; the stop bit was sampled low.
- `overrun` out 1: one-cycle pulse; a good byte was dropped because the queue was full.

## Operation
- **Bit timing:** `CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE`, using integer division. `HALF = CLKS_PER_BIT / 2`.
- **Counter:** one bit-timing counter, sized `$clog2(CLKS_PER_BIT)`, plus a 3-bit bit index.
- **Input synchroniser:** `rx` passes through a 2-flop synchroniser whose flops reset to 1; the result is `rx_s`. A third flop, `rx_d`, is used for edge detection.
- **FSM states:**
  - **IDLE:** go to START on a falling edge (`rx_d`=1, `rx_s`=0), and clear the counter. A line that is merely low does not trigger.
  - **START:** after HALF cycles, sample `rx_s`. If it is 0, go to DATA with the counter cleared. If it is 1, treat it as a glitch and return to IDLE.
  - **DATA:** every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After bit 7, go to STOP.
  - **STOP:** after CLKS_PER_BIT cycles, sample.
    - If the sample is 1 and the queue is not full: assert the FIFO write for exactly one cycle.
    - If the sample is 1 and the queue is full: pulse `overrun` and discard the byte. The queue contents are unchanged.
    - If the sample is 0: pulse `frame_err`, discard the byte, and go to BREAK.
    - Otherwise go to IDLE.
  - **BREAK:** stay until `rx_s`=1, then go to IDLE. A held-low line therefore yields exactly one `frame_err`.
- **Full check:** `full` is evaluated in the same cycle as the write. A pop in that same cycle does not rescue the byte; the drop is deterministic.
- **Pop:** `rd`=1 with `empty`=0 removes the head byte. The next byte appears on `msg` on the following cycle.
- **Simultaneous push and pop:** with the queue not full, the occupancy is unchanged.
- **Queue pointers:** wrap modulo `MSG_QUEUE_SIZE`. Occupancy runs from 0 to `MSG_QUEUE_SIZE`.

## Timing
- **Reset values:** FSM=IDLE, synchroniser flops=1, `empty`=1, `full`=0, `msg`=8'h00, `frame_err`=0, `overrun`=0.
- **Reset mid-frame:** the partial byte and the whole queue are discarded. The receiver re-arms only on the next falling edge.
- **Input latency:** 2 clocks from a `rx` pin edge to `rx_s`.
- **Stop-sample latency:** the stop bit is sampled in cycle T. The write, `frame_err` or `overrun` pulse occurs in cycle T+1. `empty` falls and `msg` is valid in cycle T+2.
- **Sample point:** each bit is sampled at its centre ±1 clock, given the synchroniser delay.
- **Throughput:** back-to-back frames are accepted. Returning to IDLE after the stop-bit sample leaves about HALF cycles to detect the next start edge.

## Structure
- **Shared package:** FSM state encoding (IDLE, START, DATA, STOP, BREAK) and the `CLKS_PER_BIT`/`HALF` derivation. The transmit side uses the same baud derivation.
- **Natural sub-module:** `uart_rx`, containing the synchroniser, FSM and shift register. Its outputs are `data_out[7:0]`, `valid` (1-cycle), `frame_err` and `busy`.
- **Top level:** instantiates `uart_rx` and the existing `fifo` (`DATA_WIDTH`=8, `FIFO_DEPTH`=`MSG_QUEUE_SIZE`). It gates `valid` with `~full` to form the FIFO write and generates `overrun`.

## Test plan
Bench parameters are `SYS_CLK_FREQ`=1_600_000, `BAUD_RATE`=100_000 (16 clocks per bit) and `MSG_QUEUE_SIZE`=4.

- **Single frame:** drive a 0x55 frame. `empty` falls 2 cycles after the stop-bit sample, `msg`=0x55, and there are no error pulses. Assert `rd` for one cycle: `empty`=1.
- **Back-to-back frames:** drive 0xA5, 0x3C, 0xFF, 0x00 with no idle gap. `full`=1. Reading yields the bytes in that order, and `empty`=1 after 4 pops.
- **Overrun:** with the queue full, send 0x12. `overrun` pulses once and the queue still reads 0xA5 first. `rd` in the stop-commit cycle still drops 0x12.
- **Framing error and break:** send 0x81 with a low stop bit, then hold `rx` low for 40 bit times. `frame_err` pulses exactly once and nothing is queued. After `rx` returns high, 0x81 with a good stop bit is received.
- **Glitch rejection:** drive a 4-clock low pulse. The FSM returns to IDLE and produces no write and no error.
- **Reset mid-frame and on empty:** assert `reset` during bit 3 of a frame with 2 bytes queued. All outputs take their reset values and the queue is empty; the next frame, 0x7E, is received correctly. Separately, `rd` while empty leaves `empty`=1 with no pointer change.
